// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 64x32 data memory.
// Port 0 is the processor and port 1 is the DMA/debug master. One access is
// performed per cycle. A granted port may keep ownership with LOCKx for at most
// MAX_BURST consecutive grants. Read data is registered and returned one cycle
// after the grant, together with a one-cycle valid pulse.
module dmem_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          REQ0,
  input  logic          LOCK0,
  input  logic          WE0,
  input  logic [AW-1:0] A0,
  input  logic [DW-1:0] WD0,
  output logic          GNT0,
  output logic [DW-1:0] RD0,
  output logic          RVALID0,
  input  logic          REQ1,
  input  logic          LOCK1,
  input  logic          WE1,
  input  logic [AW-1:0] A1,
  input  logic [DW-1:0] WD1,
  output logic          GNT1,
  output logic [DW-1:0] RD1,
  output logic          RVALID1,
  output logic [AW-1:0] MEM_A,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WD,
  input  logic [DW-1:0] MEM_RD
);

  // BCNT only has to reach MAX_BURST-1, plus one bit of headroom for the
  // incremented value used in the limit comparison.
  localparam int BCW = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t           r_owner;
  owner_t           w_owner_nxt;
  logic             r_prio;
  logic             w_prio_nxt;
  logic [BCW-1:0]   r_bcnt;
  logic [BCW-1:0]   w_bcnt_nxt;
  logic [BCW-1:0]   w_bcnt_inc;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_lock_g;
  logic [DW-1:0]    r_rd0;
  logic [DW-1:0]    r_rd1;
  logic             r_rvalid0;
  logic             r_rvalid1;

  assign w_bcnt_inc = r_bcnt + BCW'(1);

  // Grant decision: the current owner keeps the memory while it still
  // requests; otherwise a lone requester wins, and a tie goes to r_prio.
  // No grant at all while reset is asserted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!RESETN) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if ((r_owner == OWN_P0) && REQ0) begin
      w_gnt0 = 1'b1;
    end else if ((r_owner == OWN_P1) && REQ1) begin
      w_gnt1 = 1'b1;
    end else if (REQ0 && REQ1) begin
      w_gnt0 = ~r_prio;
      w_gnt1 = r_prio;
    end else if (REQ0) begin
      w_gnt0 = 1'b1;
    end else if (REQ1) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Memory mux: the granted port drives the memory; idle cycles park on
  // port 0's address/data with the write enable low.
  always_comb begin
    MEM_A  = A0;
    MEM_WD = WD0;
    MEM_WE = 1'b0;
    if (w_gnt1) begin
      MEM_A  = A1;
      MEM_WD = WD1;
      MEM_WE = WE1;
    end else if (w_gnt0) begin
      MEM_A  = A0;
      MEM_WD = WD0;
      MEM_WE = WE0;
    end else begin
      MEM_A  = A0;
      MEM_WD = WD0;
      MEM_WE = 1'b0;
    end
  end

  // Next ownership: a locked grant under the burst limit keeps the port as
  // owner; any other grant releases and hands priority to the other port.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    w_bcnt_nxt  = {BCW{1'b0}};
    w_prio_nxt  = r_prio;
    w_lock_g    = w_gnt1 ? LOCK1 : LOCK0;
    if (w_gnt0 || w_gnt1) begin
      if (w_lock_g && (w_bcnt_inc < BCW'(MAX_BURST))) begin
        w_owner_nxt = w_gnt1 ? OWN_P1 : OWN_P0;
        w_bcnt_nxt  = w_bcnt_inc;
        w_prio_nxt  = r_prio;
      end else begin
        w_owner_nxt = OWN_NONE;
        w_bcnt_nxt  = {BCW{1'b0}};
        w_prio_nxt  = ~w_gnt1;
      end
    end else begin
      w_owner_nxt = OWN_NONE;
      w_bcnt_nxt  = {BCW{1'b0}};
      w_prio_nxt  = r_prio;
    end
  end

  // Arbitration state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_owner <= OWN_NONE;
      r_prio  <= 1'b0;
      r_bcnt  <= {BCW{1'b0}};
    end else begin
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Read-return registers: capture memory data at the end of a read grant.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_rd0     <= {DW{1'b0}};
      r_rd1     <= {DW{1'b0}};
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~WE0;
      r_rvalid1 <= w_gnt1 & ~WE1;
      if (w_gnt0 && !WE0) begin
        r_rd0 <= MEM_RD;
      end else begin
        r_rd0 <= r_rd0;
      end
      if (w_gnt1 && !WE1) begin
        r_rd1 <= MEM_RD;
      end else begin
        r_rd1 <= r_rd1;
      end
    end
  end

  assign GNT0    = w_gnt0;
  assign GNT1    = w_gnt1;
  assign RD0     = r_rd0;
  assign RD1     = r_rd1;
  assign RVALID0 = r_rvalid0;
  assign RVALID1 = r_rvalid1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic        CLK;
  logic        rstn;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [1:0]  we;
  logic [5:0]  addr [2];
  logic [31:0] wdat [2];

  logic        GNT0, GNT1, RVALID0, RVALID1, MEM_WE;
  logic [31:0] RD0, RD1, MEM_WD, MEM_RD;
  logic [5:0]  MEM_A;

  // Physical memory the arbiter drives.
  logic [31:0] mem [64];
  // Reference model state.
  logic [31:0] ref_mem [64];
  int          holder;
  int          run_len;
  int          fav;
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd [2];
  int          exp_g;
  int          obs_g;
  int          first_g;

  int n_checks;
  int n_fail;

  dmem_arbiter #(.AW(6), .DW(32), .MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RESETN(rstn),
    .REQ0(req[0]), .LOCK0(lock[0]), .WE0(we[0]), .A0(addr[0]), .WD0(wdat[0]),
    .GNT0(GNT0), .RD0(RD0), .RVALID0(RVALID0),
    .REQ1(req[1]), .LOCK1(lock[1]), .WE1(we[1]), .A1(addr[1]), .WD1(wdat[1]),
    .GNT1(GNT1), .RD1(RD1), .RVALID1(RVALID1),
    .MEM_A(MEM_A), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MEM_RD = mem[MEM_A];

  // Memory: deterministic initial contents, write on rising edge.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 ^ (i * 32'h0101_0101);
  end
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_A] <= MEM_WD;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs are already set; check at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    int          g;
    logic        ewe;
    logic [5:0]  ea;
    logic [31:0] ed;
    @(negedge CLK);
    // Whoever owns the memory keeps it while asking; otherwise the favoured
    // port if it asks, else the other port if it asks.
    g = -1;
    if (rstn) begin
      if (holder >= 0 && req[holder]) g = holder;
      else if (req[fav]) g = fav;
      else if (req[1-fav]) g = 1 - fav;
    end
    obs_g = GNT0 ? 0 : (GNT1 ? 1 : -1);
    ewe = (g >= 0) ? we[g] : 1'b0;
    ea  = (g >= 0) ? addr[g] : addr[0];
    ed  = (g >= 0) ? wdat[g] : wdat[0];
    check_value("gnt0", 32'(GNT0), 32'(g == 0));
    check_value("gnt1", 32'(GNT1), 32'(g == 1));
    check_value("mem_we", 32'(MEM_WE), 32'(ewe));
    check_value("mem_a", 32'(MEM_A), 32'(ea));
    check_value("mem_wd", MEM_WD, ed);
    check_value("rvalid0", 32'(RVALID0), 32'(exp_rv[0]));
    check_value("rvalid1", 32'(RVALID1), 32'(exp_rv[1]));
    check_value("rd0", RD0, exp_rd[0]);
    check_value("rd1", RD1, exp_rd[1]);
    if (!rstn) begin
      holder = -1; run_len = 0; fav = 0;
      exp_rv = 2'b00; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    end else begin
      exp_rv = 2'b00;
      if (g >= 0) begin
        if (we[g]) ref_mem[addr[g]] = wdat[g];
        else begin
          exp_rv[g] = 1'b1;
          exp_rd[g] = ref_mem[addr[g]];
        end
        if (lock[g] && (run_len + 1 < MAXB)) begin
          holder = g; run_len = run_len + 1;
        end else begin
          holder = -1; run_len = 0; fav = 1 - g;
        end
      end else begin
        holder = -1; run_len = 0;
      end
    end
    exp_g = g;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 2'b00; lock = 2'b00;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    holder = -1; run_len = 0; fav = 0; exp_rv = 2'b00;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0; exp_g = -1;
    // Reset with both ports requesting writes: nothing may be granted or written.
    rstn = 1'b0; req = 2'b11; lock = 2'b11; we = 2'b11;
    addr[0] = 6'd3; addr[1] = 6'd4; wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
    @(posedge CLK); #1;
    step();
    step();
    rstn = 1'b1;

    // Single-port write then read of address 5.
    do_reset();
    req = 2'b01; we = 2'b01; addr[0] = 6'd5; wdat[0] = 32'hDEAD_BEEF;
    step();
    check_value("t2_wr_gnt", 32'(obs_g), 32'd0);
    we = 2'b00;
    step();
    check_value("t2_rd_gnt", 32'(obs_g), 32'd0);
    req = 2'b00;
    check_value("t2_rvalid0", 32'(RVALID0), 32'd1);
    check_value("t2_rd0", RD0, 32'hDEAD_BEEF);
    step();

    // Round-robin with both ports reading every cycle.
    do_reset();
    req = 2'b11; we = 2'b00; lock = 2'b00;
    for (int i = 0; i < 6; i++) begin
      addr[0] = 6'(i); addr[1] = 6'(i + 8);
      step();
      check_value("t3_rr", 32'(obs_g), 32'(i % 2));
    end

    // Burst limit: port 1 locked gets exactly MAXB grants, then port 0.
    do_reset();
    req = 2'b01; we = 2'b00;
    step();
    req = 2'b11; lock = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("t4_burst", 32'(obs_g), (i < 4) ? 32'd1 : 32'd0);
    end

    // Same-address write (port 0) and read (port 1) in one cycle.
    do_reset();
    req = 2'b11; we = 2'b01; addr[0] = 6'd10; addr[1] = 6'd10; wdat[0] = 32'h0000_1234;
    step();
    first_g = obs_g;
    req = 2'b10;
    step();
    check_value("t5_order0", 32'(first_g), 32'd0);
    check_value("t5_order1", 32'(obs_g), 32'd1);
    req = 2'b00;
    check_value("t5_rd1", RD1, 32'h0000_1234);
    step();

    // Reset in the middle of a port 1 locked burst.
    do_reset();
    req = 2'b01; we = 2'b00;
    step();
    req = 2'b10; lock = 2'b10;
    step();
    step();
    rstn = 1'b0; req = 2'b11;
    step();
    rstn = 1'b1;
    step();
    check_value("t6_after_rst", 32'(obs_g), 32'd0);

    // Randomized traffic; a request stays unchanged until it is granted.
    req = 2'b00;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || exp_g == p) begin
          req[p]  = ($urandom_range(0, 2) != 0);
          we[p]   = 1'($urandom_range(0, 1));
          addr[p] = 6'($urandom_range(0, 7));
          wdat[p] = $urandom;
        end
        lock[p] = ($urandom_range(0, 3) != 0);
      end
      rstn = ($urandom_range(0, 39) != 0);
      step();
    end

    // Final memory image must match every write the model accepted.
    for (int i = 0; i < 64; i++) check_value("mem_final", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
